rv32i_fetch: RTL and testbench

//  Instruction-fetch stage: owns the PC and issues one-outstanding-request reads to instruction memory.

---
 rtl/rv32i_fetch.sv | 149 ++++++++++++++
 tb/tb_rv32i_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch.sv
// RV32I instruction-fetch stage: owns the PC, keeps one memory read outstanding, skid-buffers on stall.
// Optional feature RV32I_FETCH_MISALIGN_EN: misaligned redirect targets are reported instead of being truncated.
module rv32i_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_ce,
    input  logic        i_stall,
    input  logic        i_change_pc,
    input  logic [31:0] i_new_pc,
    output logic        o_misaligned
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic [31:0] target;
    logic        locked;

    assign pc_next = pc + 32'd4;

`ifdef RV32I_FETCH_MISALIGN_EN
    logic bad_target;
    logic bad_target_now;

    assign target         = i_new_pc;
    assign bad_target_now = |i_new_pc[1:0];
    // A reported misaligned target parks the fetcher until the next redirect
    assign locked         = o_misaligned;
`else
    logic unused_new_pc_lsbs;

    assign target             = {i_new_pc[31:2], 2'b00};
    assign locked             = 1'b0;
    assign o_misaligned       = 1'b0;
    assign unused_new_pc_lsbs = ^i_new_pc[1:0];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= FETCH;
            pc         <= PC_RESET;
            o_stb_inst <= 1'b0;
            o_iaddr    <= 32'd0;
            o_inst     <= 32'd0;
            o_pc       <= 32'd0;
            o_ce       <= 1'b0;
            skid_inst  <= 32'd0;
            skid_pc    <= 32'd0;
`ifdef RV32I_FETCH_MISALIGN_EN
            o_misaligned <= 1'b0;
            bad_target   <= 1'b0;
`endif
        end else if (i_change_pc) begin
            pc        <= target;
            skid_inst <= 32'd0;
            skid_pc   <= 32'd0;
            o_ce      <= 1'b0;
`ifdef RV32I_FETCH_MISALIGN_EN
            o_misaligned <= 1'b0;
            bad_target   <= bad_target_now;
`endif
            // A request still on the bus cannot be aborted; wait for its ack and throw the data away
            if (o_stb_inst && !i_ack_inst) begin
                state <= DRAIN;
            end else begin
                state      <= FETCH;
                o_stb_inst <= 1'b0;
`ifdef RV32I_FETCH_MISALIGN_EN
                if (bad_target_now) begin
                    o_misaligned <= 1'b1;
                    o_ce         <= 1'b1;
                    o_pc         <= i_new_pc;
                    o_inst       <= NOP;
                end
`endif
            end
        end else begin
            case (state)
                FETCH: begin
                    if (o_stb_inst) begin
                        if (i_ack_inst && !i_stall) begin
                            o_inst  <= i_inst;
                            o_pc    <= pc;
                            o_ce    <= 1'b1;
                            pc      <= pc_next;
                            o_iaddr <= pc_next;
                        end else if (i_ack_inst) begin
                            skid_inst  <= i_inst;
                            skid_pc    <= pc;
                            pc         <= pc_next;
                            o_stb_inst <= 1'b0;
                            state      <= HOLD;
                        end else if (!i_stall) begin
                            o_ce <= 1'b0;
                        end
                    end else begin
                        if (!i_stall) begin
                            o_ce <= 1'b0;
                        end
                        if (!locked) begin
                            o_stb_inst <= 1'b1;
                            o_iaddr    <= pc;
                        end
                    end
                end
                HOLD: begin
                    if (!i_stall) begin
                        o_inst    <= skid_inst;
                        o_pc      <= skid_pc;
                        o_ce      <= 1'b1;
                        skid_inst <= 32'd0;
                        skid_pc   <= 32'd0;
                        state     <= FETCH;
                    end
                end
                DRAIN: begin
                    if (i_ack_inst) begin
                        o_stb_inst <= 1'b0;
                        state      <= FETCH;
`ifdef RV32I_FETCH_MISALIGN_EN
                        if (bad_target) begin
                            o_misaligned <= 1'b1;
                            o_ce         <= 1'b1;
                            o_pc         <= pc;
                            o_inst       <= NOP;
                        end
`endif
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_fetch.sv
// Self-checking bench for rv32i_fetch: directed scenarios plus random ack/stall/redirect traffic
// checked against a transaction-level model of the fetch stream.
module tb_rv32i_fetch;

    localparam logic [31:0] PC_RESET = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] o_iaddr;
    logic        o_stb_inst;
    logic        i_ack_inst;
    logic [31:0] i_inst;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_ce;
    logic        i_stall;
    logic        i_change_pc;
    logic [31:0] i_new_pc;
    logic        o_misaligned;

    int checks   = 0;
    int failures = 0;

    // Model state: next PC expected at the decode side, next address expected on the bus
    logic [31:0] expPc;
    logic [31:0] expReq;
    logic        stale;
    logic        expNop;

    logic [31:0] savedAddr;
    logic [31:0] randTarget;

    rv32i_fetch #(.PC_RESET(PC_RESET)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_iaddr      (o_iaddr),
        .o_stb_inst   (o_stb_inst),
        .i_ack_inst   (i_ack_inst),
        .i_inst       (i_inst),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_ce         (o_ce),
        .i_stall      (i_stall),
        .i_change_pc  (i_change_pc),
        .i_new_pc     (i_new_pc),
        .o_misaligned (o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Clock one edge and compare the DUT with the fetch-stream model
    task automatic clockAndCheck();
        logic        pStb, pAck, pStall, pChg, pRst, pCe;
        logic [31:0] pAddr, pNew, pInst, pPc, tgt;
        pStb = o_stb_inst; pAddr = o_iaddr; pAck = i_ack_inst; pStall = i_stall;
        pChg = i_change_pc; pRst = i_rst; pCe = o_ce; pInst = o_inst; pPc = o_pc; pNew = i_new_pc;
        @(posedge i_clk);
        #1;
        if (pRst) begin
            expPc = PC_RESET; expReq = PC_RESET; stale = 1'b0; expNop = 1'b0;
            checkOutput("reset_stb", 32'(o_stb_inst), 32'd0);
            checkOutput("reset_ce", 32'(o_ce), 32'd0);
        end else begin
            if (pStb && !pAck) begin
                checkOutput("bus_hold_stb", 32'(o_stb_inst), 32'd1);
                checkOutput("bus_hold_addr", o_iaddr, pAddr);
            end
            if (pStb && pAck) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    checkOutput("req_addr", pAddr, expReq);
                    expReq = expReq + 32'd4;
                end
            end
            if (pCe && !pStall) begin
                checkOutput("out_pc", pPc, expPc);
                checkOutput("out_inst", pInst, expNop ? NOP : memWord(expPc));
                if (!expNop) expPc = expPc + 32'd4;
            end else if (pCe && !pChg) begin
                checkOutput("hold_ce", 32'(o_ce), 32'd1);
                checkOutput("hold_pc", o_pc, pPc);
                checkOutput("hold_inst", o_inst, pInst);
            end
            if (expNop && !pChg) checkOutput("locked_stb", 32'(o_stb_inst), 32'd0);
            if (pChg) begin
                tgt    = {pNew[31:2], 2'b00};
                expNop = 1'b0;
`ifdef RV32I_FETCH_MISALIGN_EN
                if (pNew[1:0] != 2'b00) begin
                    tgt    = pNew;
                    expNop = 1'b1;
                end
`endif
                expPc  = tgt;
                expReq = tgt;
                stale  = pStb && !pAck;
                checkOutput("flush_ce", 32'(o_ce), 32'(expNop));
            end
        end
    endtask

    task automatic applyStimulus(input logic ackEn, input logic stall, input logic chg, input logic [31:0] newPc);
        i_ack_inst  = o_stb_inst & ackEn;
        i_inst      = memWord(o_iaddr);
        i_stall     = stall;
        i_change_pc = chg;
        i_new_pc    = newPc;
        clockAndCheck();
    endtask

    task automatic waitForStb();
        int n = 0;
        while (o_stb_inst !== 1'b1 && n < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            n++;
        end
        checkOutput("stb_timeout", 32'(o_stb_inst), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_rst = 1'b1; i_ack_inst = 1'b0; i_inst = 32'd0; i_stall = 1'b0;
        i_change_pc = 1'b0; i_new_pc = 32'd0;
        expPc = PC_RESET; expReq = PC_RESET; stale = 1'b0; expNop = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        i_rst = 1'b0;

        // Zero-wait memory after reset: one instruction per cycle, PC wraps past 2^32
        checkOutput("t1_c0_stb", 32'(o_stb_inst), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t1_c1_stb", 32'(o_stb_inst), 32'd1);
        checkOutput("t1_c1_addr", o_iaddr, PC_RESET);
        for (int k = 2; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
            checkOutput("t1_ce", 32'(o_ce), 32'd1);
            checkOutput("t1_pc", o_pc, PC_RESET + 32'(4 * (k - 2)));
        end

        // Ack under stall goes to the skid buffer and is released when the stall drops
        waitForStb();
        savedAddr = o_iaddr;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("t2_stb_idle", 32'(o_stb_inst), 32'd0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
            checkOutput("t2_stb_idle", 32'(o_stb_inst), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_release_ce", 32'(o_ce), 32'd1);
        checkOutput("t2_release_pc", o_pc, savedAddr);
        checkOutput("t2_release_inst", o_inst, memWord(savedAddr));
        waitForStb();
        checkOutput("t2_next_addr", o_iaddr, savedAddr + 32'd4);

        // Redirect with a request outstanding: drain it, then fetch the target
        savedAddr = o_iaddr;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        checkOutput("t3_addr_kept", o_iaddr, savedAddr);
        checkOutput("t3_ce", 32'(o_ce), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("t3_addr_kept", o_iaddr, savedAddr);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t3_drain_ce", 32'(o_ce), 32'd0);
        waitForStb();
        checkOutput("t3_target_addr", o_iaddr, 32'h0000_0100);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t3_target_pc", o_pc, 32'h0000_0100);

        // Redirect in the same cycle as an ack: that data is dropped
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        checkOutput("t4_drop_ce", 32'(o_ce), 32'd0);
        waitForStb();
        checkOutput("t4_target_addr", o_iaddr, 32'h0000_0200);

        // Reset while draining; a late ack after reset must be ignored
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        i_rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        i_rst = 1'b0;
        i_ack_inst = 1'b1; i_inst = 32'hDEAD_BEEF; i_stall = 1'b0; i_change_pc = 1'b0;
        clockAndCheck();
        checkOutput("t5_ce", 32'(o_ce), 32'd0);
        checkOutput("t5_addr", o_iaddr, PC_RESET);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t5_pc", o_pc, PC_RESET);

        // Misaligned redirect issued from the idle skid state
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0102);
`ifdef RV32I_FETCH_MISALIGN_EN
        checkOutput("t6_misaligned", 32'(o_misaligned), 32'd1);
        checkOutput("t6_pc", o_pc, 32'h0000_0102);
        checkOutput("t6_inst", o_inst, NOP);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        checkOutput("t6_clear", 32'(o_misaligned), 32'd0);
        waitForStb();
        checkOutput("t6_addr", o_iaddr, 32'h0000_0040);
`else
        checkOutput("t6_misaligned", 32'(o_misaligned), 32'd0);
        waitForStb();
        checkOutput("t6_addr", o_iaddr, 32'h0000_0100);
`endif

        // Random ack, stall, redirect and occasional reset traffic
        for (int i = 0; i < 800; i++) begin
            randTarget = 32'($urandom_range(0, 32'hFFF));
`ifdef RV32I_FETCH_MISALIGN_EN
            randTarget[1:0] = 2'b00;
`endif
            i_rst = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                          $urandom_range(0, 19) == 0, randTarget);
            if (o_misaligned !== 1'b0 && !expNop) checkOutput("rand_misaligned", 32'(o_misaligned), 32'd0);
        end
        i_rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
